// File: rtl/inst_fetch_port.sv
// Instruction fetch port: bridges the PC stage to a split addr/data instruction bus.
// Optional fetch-stall cycle counter enabled by defining IFP_STALL_CNT_EN.
module inst_fetch_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [31:0] pc,
   input  logic        i_excp,
   input  logic        pl_stall,
   input  logic        flush,
   output logic        stall_req,
   output logic [31:0] inst,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_addr_ok,
   input  logic        ibus_data_ok,
   input  logic [31:0] ibus_rdata,
   output logic [31:0] stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE,
      S_DISCARD
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_hold_buf;
   logic        w_fetch;
   logic        w_req;
   logic        w_capture;

   assign w_fetch = i_en & ~i_excp & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hold_buf <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) r_hold_buf <= ibus_rdata;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_req     = 1'b0;
      w_capture = 1'b0;
      inst      = '0;
      case (r_state)
         S_IDLE, S_ADDR: begin
            w_req = w_fetch;
            if (w_fetch) w_next = ibus_addr_ok ? S_DATA : S_ADDR;
            else         w_next = S_IDLE;
         end
         S_DATA: begin
            if (ibus_data_ok) begin
               if (flush) begin
                  w_next = S_IDLE;
               end else begin
                  inst = ibus_rdata;
                  if (pl_stall) begin
                     w_capture = 1'b1;
                     w_next    = S_DONE;
                  end else begin
                     w_next = S_IDLE;
                  end
               end
            end else if (flush) begin
               w_next = S_DISCARD;
            end
         end
         S_DONE: begin
            inst = r_hold_buf;
            if (flush || !pl_stall) w_next = S_IDLE;
         end
         S_DISCARD: begin
            // The abandoned access must still drain before a new one may issue.
            if (ibus_data_ok) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign ibus_req  = w_req & ~rst;
   assign ibus_addr = pc;

   always_comb begin
      if (r_state == S_DISCARD)
         stall_req = ~flush;
      else
         stall_req = w_fetch & ~((r_state == S_DATA) & ibus_data_ok) & ~(r_state == S_DONE);
   end

`ifdef IFP_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (stall_req && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/inst_fetch_port.md
INST_FETCH_PORT -- requirements
Module: inst_fetch_port

Interface
REQ-001 clk  in  1  system clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 i_en  in  1  fetch-enable from the PC stage; pc is a valid fetch address when 1.
REQ-004 pc  in  32  fetch address.
REQ-005 i_excp  in  1  fetch address error (AdEL) for the current pc; suppresses the bus access.
REQ-006 pl_stall  in  1  stall from the downstream pipeline; the IF/ID register holds when 1.
REQ-007 flush  in  1  pipeline flush; the current and in-flight fetches are abandoned.
REQ-008 stall_req  out  1  fetch-not-complete stall request to the stall controller.
REQ-009 inst  out  32  fetched instruction word, valid when stall_req=0.
REQ-010 ibus_req, ibus_addr  out  1/32  bus request and address (address = pc).
REQ-011 ibus_addr_ok, ibus_data_ok, ibus_rdata  in  1/1/32  address accept, data return, read data.
REQ-012 stall_cnt  out  32  fetch-stall cycle counter (see Configuration).

Function
REQ-013 States: IDLE, ADDR, DATA, DONE, DISCARD; at most one request is outstanding.
REQ-014 IDLE and ADDR: ibus_req = i_en & ~i_excp & ~flush; ibus_addr = pc combinationally; ibus_req=0 in DATA, DONE and DISCARD.
REQ-015 IDLE/ADDR, ibus_req=1 & addr_ok=1 -> DATA; ibus_req=1 & addr_ok=0 -> ADDR; ibus_req=0 -> IDLE.
REQ-016 ADDR: ibus_addr = pc, which is held by the stall; a request, once issued, is never withdrawn except by flush.
REQ-017 DATA & data_ok=1: inst = ibus_rdata combinationally (zero added latency); -> IDLE if pl_stall=0; if pl_stall=1, capture rdata into hold_buf and -> DONE.
REQ-018 DONE: inst = hold_buf; -> IDLE when pl_stall=0.
REQ-019 stall_req = i_en & ~i_excp & ~flush & ~(DATA & data_ok) & ~DONE; stall_req = 1 in DISCARD whenever flush=0.
REQ-020 Address error: for i_en=1 & i_excp=1, no bus request is made, inst = 0 (NOP), and stall_req=0.
REQ-021 For i_en=0, inst = 0 and no request is made.
REQ-022 Flush in IDLE, DONE, or in ADDR without addr_ok -> IDLE, with no request issued that cycle.
REQ-023 Flush in DATA: data_ok=1 -> IDLE with the data dropped; data_ok=0 -> DISCARD.
REQ-024 Flush in DISCARD -> remain in DISCARD.
REQ-025 DISCARD: wait for data_ok, drop the data, then -> IDLE; inst = 0.
REQ-026 Minimum fetch latency is 2 cycles: request in cycle N, data_ok in cycle N+1, IF/ID capture at the end of N+1.

Reset
REQ-027 On rst=1, immediately and independently of clk: state=IDLE, hold_buf=0, stall_cnt=0; ibus_req is forced to 0 while rst=1.
REQ-028 Reset mid-transaction abandons the outstanding access; the bus interconnect is reset by the same rst.

Configuration
REQ-029 Macro IFP_STALL_CNT_EN, when defined: stall_cnt increments by 1 on each clock with stall_req=1 and saturates at 32'hFFFF_FFFF.
REQ-030 Macro IFP_STALL_CNT_EN, when undefined: stall_cnt is constant 0, with no counter flip-flops and unchanged fetch behaviour.

Verification
REQ-031 Scenario: pc=0xBFC00000, addr_ok in cycle 0, data_ok with rdata=0x24080001 in cycle 1, pl_stall=0 -> stall_req=1 in cycle 0 and 0 in cycle 1; inst=0x24080001 in cycle 1.
REQ-032 Scenario: addr_ok delayed 3 cycles -> ibus_req and ibus_addr are held stable for 4 cycles; stall_req=1 throughout; with IFP_STALL_CNT_EN, stall_cnt=5 after data_ok in cycle 5.
REQ-033 Scenario: data_ok with rdata=0x12345678 while pl_stall=1 for 3 cycles -> state DONE, inst=0x12345678 held with stall_req=0, no new ibus_req until pl_stall=0.
REQ-034 Scenario: flush in DATA, data_ok 2 cycles later -> DISCARD, inst=0 and ibus_req=0 until data_ok, then a new request to the flush target the next cycle.
REQ-035 Scenario: pc=0xBFC00002, i_excp=1 -> ibus_req=0, inst=0, stall_req=0 in the same cycle.
REQ-036 Scenario: rst asserted in DATA -> ibus_req=0 and stall_cnt=0 immediately; IDLE after release, with a fresh request on the first i_en.
